execute_stage: RTL
==================

# execute_stage

Execute stage of the RV64I+Zba five-stage pipeline. It consumes the decode/execute register outputs and applies operand forwarding. It computes the 64-bit ALU result, including Zba and RV64 W-ops, and resolves branches and jumps with a same-cycle redirect. It also contains the EX/MEM pipeline register, which supports stall and flush and feeds the memory stage.

## Interface
- No parameters; XLEN fixed at 64.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- stall_M  in  1  hold EX/MEM register contents.
- flush_M  in  1  load a bubble into EX/MEM.
- RD1_E / RD2_E / PC_E / ImmExt_E  in  64 each  register operands, instruction PC, extended immediate.
- Rd_E  in  5  destination register.
- op_E  in  7  opcode; 0 denotes a bubble.
- RegWrite_E / MemWrite_E / ALUSrc_E / Branch_E / Jump_E / is_jalr_E  in  1 each  decoded controls.
- ResultSrc_E  in  2  writeback select: 00 ALU, 01 load, 10 PC+4.
- ALUControl_E  in  5  ALU operation code (see Structure).
- funct3_E  in  3  branch condition / memory size.
- ForwardA_E / ForwardB_E  in  2 each  operand select from the hazard unit: 00 RD, 01 Result_W, 10 ALUResult_M, 11 RD.
- Result_W  in  64  writeback-stage result.
- PCSrc_E  out  1  redirect fetch this cycle.
- PCTarget_E  out  64  redirect target.
- ALUResult_M / WriteData_M / PCPlus4_M  out  64 each  registered ALU result, forwarded rs2, PC_E+4.
- Rd_M  out  5  registered destination register.
- funct3_M  out  3  registered funct3.
- ResultSrc_M  out  2  registered writeback select.
- RegWrite_M / MemWrite_M / valid_M  out  1 each  registered controls; valid_M = (op_E != 0).

## Operation
- SrcA: forwarded rs1, replaced by PC_E when op_E = 7'b0010111 (AUIPC).
- WriteData: forwarded rs2.
- SrcB: ImmExt_E if ALUSrc_E, else WriteData.
- ALU ops are 64-bit wrap-around.
- W-ops: compute on the low 32 bits, then sign-extend bit 31 to 64.
- Shift amounts: bits [5:0] for 64-bit shifts, bits [4:0] for W-ops.
- SLT/SLTU: produce 64'd0 or 64'd1.
- Zba shNadd: (A<<N)+B.
- add.uw / shNadd.uw: zero-extend A[31:0] before the shift.
- slli.uw: zext(A[31:0]) << B[5:0].
- LUI: passes SrcB.
- Branch condition by funct3_E: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; 010/011 never taken. Compares forwarded rs1 against forwarded rs2.
- PCTarget_E: (SrcA_fwd + ImmExt_E) & ~64'd1 when is_jalr_E, else PC_E + ImmExt_E.
- PCSrc_E = ((Branch_E & cond) | Jump_E) & ~stall_M.
- EX/MEM register update per rising edge:
  - flush_M: bubble. All controls 0, valid_M 0, data fields 0.
  - else stall_M: hold every field.
  - else capture the E-stage values.
- Update priority: rst_n > flush_M > stall_M > capture.
- Bubble from DE (all-zero controls) propagates as valid_M=0 and never redirects.

## Timing
- PCSrc_E and PCTarget_E: combinational, same cycle as the instruction in E. The hazard unit flushes D and E on the next edge.
- EX/MEM outputs: registered, latency 1 cycle.
- Forwarding: ALUResult_M feeds back internally for back-to-back dependences with zero added stall.
- Reset, asynchronous assert: all registered outputs go to 0 immediately, including valid_M=0.
- Reset deassert: synchronous to clk, handled by the top-level synchronizer.
- Reset mid-operation: the in-flight EX/MEM instruction is discarded.
- Simultaneous flush_M and stall_M: flush wins.
- stall_M with a taken branch in E: the redirect is suppressed and re-evaluated when the stall releases.

## Structure
- Shared package ex_pkg holds:
  - alu_op_e, 5-bit: ADD=0, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, ADDW, SUBW, SLLW, SRLW, SRAW, SH1ADD, SH2ADD, SH3ADD, ADDUW, SH1ADDUW, SH2ADDUW, SH3ADDUW, SLLIUW, LUI=23.
  - Opcode constants OP_AUIPC and OP_JALR.
  - fwd_sel_e.
- Sub-module alu64: purely combinational, operands plus alu_op_e in, 64-bit result out. Branch compare and the register stay in execute_stage.
- alu64 codes 24–31 return 64'd0.

## Test plan
- ADD with ForwardA=10 after a prior ADD writing x5=7, plus x6=3: ALUResult_M = 10 one cycle later, no stall.
- ADDW with A=64'h0000_0000_7FFF_FFFF, B=1: result 64'hFFFF_FFFF_8000_0000.
- SH3ADD.UW with A=64'hFFFF_FFFF_0000_0002, B=5: result 21. SLLI.UW with A=64'hFFFF_FFFF_8000_0000, shamt 4: result 64'h8_0000_0000.
- BLT taken (rs1=-1, rs2=1, PC_E=0x100, imm=-8): PCSrc_E=1, PCTarget_E=0xF8. Same cycle with stall_M=1: PCSrc_E=0.
- JALR with rs1=0x1003, imm=4: PCTarget_E=0x1006, PCPlus4_M=PC_E+4, ResultSrc_M=10.
- Assert flush_M and stall_M together: valid_M=0 and RegWrite_M=0 next cycle. Drop rst_n mid-stream: all outputs 0 without a clock edge.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types for the RV64I+Zba execute stage.
// ALU op codes, forwarding selects, opcode constants and the EX/MEM bundle.
package ex_pkg;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_ADDW,
        ALU_SUBW,
        ALU_SLLW,
        ALU_SRLW,
        ALU_SRAW,
        ALU_SH1ADD,
        ALU_SH2ADD,
        ALU_SH3ADD,
        ALU_ADDUW,
        ALU_SH1ADDUW,
        ALU_SH2ADDUW,
        ALU_SH3ADDUW,
        ALU_SLLIUW,
        ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RD    = 2'b00,
        FWD_W     = 2'b01,
        FWD_M     = 2'b10,
        FWD_RD_HI = 2'b11
    } fwd_sel_e;

    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef struct packed {
        logic [63:0] alu_result;
        logic [63:0] write_data;
        logic [63:0] pc_plus4;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [1:0]  result_src;
        logic        reg_write;
        logic        mem_write;
        logic        valid;
    } ex_mem_t;

    function automatic logic [63:0] sext_w(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/alu64.sv
// Combinational 64-bit ALU: RV64I base ops, W-ops and Zba.
// Unassigned op codes yield zero.
module alu64
    import ex_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  alu_op_e     op,
    output logic [63:0] y
);

    logic [63:0]        a_uw;
    logic signed [63:0] a_s;
    logic signed [31:0] a_ws;
    logic [31:0]        addw;
    logic [31:0]        subw;
    logic [31:0]        sllw;
    logic [31:0]        srlw;
    logic [31:0]        sraw;

    assign a_uw = {32'd0, a[31:0]};
    assign a_s  = a;
    assign a_ws = a[31:0];
    assign addw = a[31:0] + b[31:0];
    assign subw = a[31:0] - b[31:0];
    assign sllw = a[31:0] << b[4:0];
    assign srlw = a[31:0] >> b[4:0];
    assign sraw = a_ws >>> b[4:0];

    always_comb begin
        y = 64'd0;
        case (op)
            ALU_ADD:      y = a + b;
            ALU_SUB:      y = a - b;
            ALU_AND:      y = a & b;
            ALU_OR:       y = a | b;
            ALU_XOR:      y = a ^ b;
            ALU_SLL:      y = a << b[5:0];
            ALU_SRL:      y = a >> b[5:0];
            ALU_SRA:      y = a_s >>> b[5:0];
            ALU_SLT:      y = {63'd0, $signed(a) < $signed(b)};
            ALU_SLTU:     y = {63'd0, a < b};
            ALU_ADDW:     y = sext_w(addw);
            ALU_SUBW:     y = sext_w(subw);
            ALU_SLLW:     y = sext_w(sllw);
            ALU_SRLW:     y = sext_w(srlw);
            ALU_SRAW:     y = sext_w(sraw);
            ALU_SH1ADD:   y = (a << 1) + b;
            ALU_SH2ADD:   y = (a << 2) + b;
            ALU_SH3ADD:   y = (a << 3) + b;
            ALU_ADDUW:    y = a_uw + b;
            ALU_SH1ADDUW: y = (a_uw << 1) + b;
            ALU_SH2ADDUW: y = (a_uw << 2) + b;
            ALU_SH3ADDUW: y = (a_uw << 3) + b;
            ALU_SLLIUW:   y = a_uw << b[5:0];
            ALU_LUI:      y = b;
            default:      y = 64'd0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: forwarding, ALU, branch/jump resolution
// and the EX/MEM pipeline register.
module execute_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_M,
    input  logic        flush_M,
    input  logic [63:0] RD1_E,
    input  logic [63:0] RD2_E,
    input  logic [63:0] PC_E,
    input  logic [63:0] ImmExt_E,
    input  logic [4:0]  Rd_E,
    input  logic [6:0]  op_E,
    input  logic        RegWrite_E,
    input  logic        MemWrite_E,
    input  logic        ALUSrc_E,
    input  logic        Branch_E,
    input  logic        Jump_E,
    input  logic        is_jalr_E,
    input  logic [1:0]  ResultSrc_E,
    input  logic [4:0]  ALUControl_E,
    input  logic [2:0]  funct3_E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [63:0] Result_W,
    output logic        PCSrc_E,
    output logic [63:0] PCTarget_E,
    output logic [63:0] ALUResult_M,
    output logic [63:0] WriteData_M,
    output logic [63:0] PCPlus4_M,
    output logic [4:0]  Rd_M,
    output logic [2:0]  funct3_M,
    output logic [1:0]  ResultSrc_M,
    output logic        RegWrite_M,
    output logic        MemWrite_M,
    output logic        valid_M
);

    logic [63:0] rs1_fwd;
    logic [63:0] rs2_fwd;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic [63:0] alu_y;
    logic        cond;
    ex_mem_t     d;
    ex_mem_t     q;

    always_comb begin
        rs1_fwd = RD1_E;
        case (fwd_sel_e'(ForwardA_E))
            FWD_W:   rs1_fwd = Result_W;
            FWD_M:   rs1_fwd = ALUResult_M;
            default: rs1_fwd = RD1_E;
        endcase
    end

    always_comb begin
        rs2_fwd = RD2_E;
        case (fwd_sel_e'(ForwardB_E))
            FWD_W:   rs2_fwd = Result_W;
            FWD_M:   rs2_fwd = ALUResult_M;
            default: rs2_fwd = RD2_E;
        endcase
    end

    assign src_a = (op_E == OP_AUIPC) ? PC_E : rs1_fwd;
    assign src_b = ALUSrc_E ? ImmExt_E : rs2_fwd;

    alu64 u_alu (
        .a  (src_a),
        .b  (src_b),
        .op (alu_op_e'(ALUControl_E)),
        .y  (alu_y)
    );

    always_comb begin
        cond = 1'b0;
        case (funct3_E)
            3'b000:  cond = (rs1_fwd == rs2_fwd);
            3'b001:  cond = (rs1_fwd != rs2_fwd);
            3'b100:  cond = ($signed(rs1_fwd) < $signed(rs2_fwd));
            3'b101:  cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
            3'b110:  cond = (rs1_fwd < rs2_fwd);
            3'b111:  cond = (rs1_fwd >= rs2_fwd);
            default: cond = 1'b0;
        endcase
    end

    // A stalled redirect is dropped here and re-raised once M releases.
    assign PCSrc_E    = ((Branch_E & cond) | Jump_E) & ~stall_M;
    assign PCTarget_E = is_jalr_E ? ((rs1_fwd + ImmExt_E) & ~64'd1)
                                  : (PC_E + ImmExt_E);

    always_comb begin
        d.alu_result = alu_y;
        d.write_data = rs2_fwd;
        d.pc_plus4   = PC_E + 64'd4;
        d.rd         = Rd_E;
        d.funct3     = funct3_E;
        d.result_src = ResultSrc_E;
        d.reg_write  = RegWrite_E;
        d.mem_write  = MemWrite_E;
        d.valid      = (op_E != 7'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush_M) begin
            q <= '0;
        end else if (!stall_M) begin
            q <= d;
        end
    end

    assign ALUResult_M = q.alu_result;
    assign WriteData_M = q.write_data;
    assign PCPlus4_M   = q.pc_plus4;
    assign Rd_M        = q.rd;
    assign funct3_M    = q.funct3;
    assign ResultSrc_M = q.result_src;
    assign RegWrite_M  = q.reg_write;
    assign MemWrite_M  = q.mem_write;
    assign valid_M     = q.valid;

endmodule
